cdc_hs_tx: RTL

- Sender-side controller for a four-phase req/ack multi-bit clock-domain crossing.
- Accepts a word through a valid/ready port and holds it stable on o_data while driving o_req.
- Brings the asynchronous i_ack into its own domain through the existing N-stage synchronizer, and sequences the req/ack protocol.
- Sits beside async_fifo as the low-rate CDC path for configuration and status words.

---
 rtl/cdc_hs_pkg.sv | 27 ++
 rtl/sync.sv | 37 +++
 rtl/cdc_hs_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cdc_hs_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hs_pkg
//   Shared types and helpers for the four-phase req/ack CDC sender.
//   - hs_state_e : handshake sequencer states
//   - cnt_width  : bit width of the wait-state timeout counter
// -----------------------------------------------------------------------------
package cdc_hs_pkg;

  // IDLE : waiting for a source word
  // REQ  : o_req high, waiting for the synchronized ack to rise
  // REL  : o_req low, waiting for the synchronized ack to fall
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

  // Width needed to hold 0..timeout. A disabled timeout (0) still gets a
  // one-bit counter so the register never collapses to zero width.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    if (timeout == 0) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sync.sv
// -----------------------------------------------------------------------------
// sync
//   N-stage single-bit synchronizer for an asynchronous level.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset, clears every stage
//     d     - asynchronous input level
//     q     - synchronized level, NSYNC edges after d changes
// -----------------------------------------------------------------------------
module sync #(
  parameter int unsigned NSYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [NSYNC-1:0] ff_q;
  logic [NSYNC-1:0] ff_d;

  // Shift the input in at bit 0; the oldest sample sits at the top.
  always_comb begin
    ff_d = {ff_q[NSYNC-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[NSYNC-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// cdc_hs_tx
//   Sender side of a four-phase req/ack multi-bit clock-domain crossing.
//   A word accepted on the valid/ready port is held on o_data while o_req
//   is raised; the destination's asynchronous ack is synchronized locally
//   and the req/ack sequence (req up, ack up, req down, ack down) is run to
//   completion before the next word is taken.
//   Ports:
//     clk, rst       - clock, asynchronous active-high reset
//     i_valid/i_data - source word offer
//     o_ready        - a word can be taken this cycle
//     o_req          - registered request to the destination domain
//     o_data         - captured word, changes only on acceptance
//     i_ack          - asynchronous acknowledge from the destination
//     o_done         - one-cycle pulse when a handshake completes
//     o_timeout      - one-cycle pulse when a wait reaches TIMEOUT cycles
//     o_err          - sticky timeout flag, cleared by i_err_clr
// -----------------------------------------------------------------------------
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NSYNC   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_req,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ack,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_err,
  input  logic             i_err_clr
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  hs_state_e        state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ack_s;
  logic             rst_n;
  logic             ready;

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer
  // ---------------------------------------------------------------------------
  assign rst_n = ~rst;

  sync #(
    .NSYNC(NSYNC)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (i_ack),
    .q    (ack_s)
  );

  // A stale ack still high (e.g. after a sender-only reset mid-transfer)
  // must drain before a new request may start.
  assign ready = (state_q == IDLE) && !ack_s;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_valid && ready) begin
          data_d  = i_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = REL;
        end else if (TO_EN && (cnt_q != TO_MAX)) begin
          // Counter saturates at TIMEOUT, so the pulse fires only once
          // per wait even if the destination never answers.
          cnt_d     = cnt_q + 1'b1;
          timeout_d = (cnt_q == TO_LAST);
        end
      end

      REL: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (TO_EN && (cnt_q != TO_MAX)) begin
          cnt_d     = cnt_q + 1'b1;
          timeout_d = (cnt_q == TO_LAST);
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Set dominates a simultaneous clear.
    err_d = timeout_d | (err_q & ~i_err_clr);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      data_q    <= data_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ready   = ready;
  assign o_req     = req_q;
  assign o_data    = data_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_err     = err_q;

endmodule
